// File: rtl/shift_add_multiplier_24bit.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier_24bit
//
// Sequential radix-2 shift-and-add multiplier. Two WIDTH-bit operands are
// captured on a start pulse, and a 2*WIDTH-bit product comes back after a
// fixed WIDTH+1 cycle latency. The handshake is the same as the restoring
// divider's, so one controller can drive either unit.
//
// Signed operation works on magnitudes. The sign is applied to the magnitude
// product in the FINISH cycle.
//
// Ports:
//   clk           system clock, rising edge active
//   reset         asynchronous, active-high, clears all state
//   start         request strobe, only looked at while idle
//   multiplicand  operand A, captured on the accepting edge
//   multiplier    operand B, captured on the accepting edge
//   signed_mode   1 = two's-complement operands, 0 = unsigned
//   product       2*WIDTH-bit result, held until the next completion
//   busy          high from the accepting edge until the completing edge
//   done          single-cycle completion pulse
// ----------------------------------------------------------------------------
module shift_add_multiplier_24bit #(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      count, count_n;
    logic [2*WIDTH:0]   acc, acc_n;
    logic [WIDTH-1:0]   mcand, mcand_n;
    logic               neg, neg_n;
    logic [2*WIDTH-1:0] product_n;
    logic               busy_n, done_n;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;
    logic [2*WIDTH-1:0] mag_product;

    // The most negative value has magnitude 2^(WIDTH-1). That magnitude is
    // still a valid WIDTH-bit unsigned number, so plain negation is enough.
    assign a_mag = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign b_mag = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;

    // acc[2*WIDTH] is always zero after a shift. Using it as the top sum bit
    // gives the same value as a zero-extended upper half.
    assign sum         = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
    assign shifted     = {sum, acc[WIDTH-1:0]} >> 1;
    assign mag_product = acc[2*WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            mcand   <= '0;
            neg     <= 1'b0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            acc     <= acc_n;
            mcand   <= mcand_n;
            neg     <= neg_n;
            product <= product_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        acc_n     = acc;
        mcand_n   = mcand;
        neg_n     = neg;
        product_n = product;
        busy_n    = busy;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    mcand_n = a_mag;
                    acc_n   = {{(WIDTH+1){1'b0}}, b_mag};
                    count_n = CW'(WIDTH);
                    neg_n   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                acc_n   = shifted;
                count_n = count - CW'(1);
                if (count == CW'(1)) begin
                    state_n = FINISH;
                end
            end
            FINISH: begin
                product_n = neg ? -mag_product : mag_product;
                done_n    = 1'b1;
                busy_n    = 1'b0;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_add_multiplier_24bit.sv
// ----------------------------------------------------------------------------
// tb_shift_add_multiplier_24bit
//
// Bench for shift_add_multiplier_24bit. A table of operand vectors runs
// through the multiplier one operation at a time. Hand-written sequences
// cover the handshake and reset corner cases.
//
// When an operation is launched, its expected product and accepting cycle
// are pushed to a scoreboard. They are popped when done is seen.
// ----------------------------------------------------------------------------
module tb_shift_add_multiplier_24bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] multiplicand;
    logic [23:0] multiplier;
    logic        signed_mode;
    logic [47:0] product;
    logic        busy;
    logic        done;

    shift_add_multiplier_24bit #(.WIDTH(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_mode  (signed_mode),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        string       name;
        logic [23:0] a;
        logic [23:0] b;
        bit          sm;
        logic [47:0] expected;
    } vec_t;

    typedef struct {
        logic [47:0] expected;
        int          accept_cycle;
    } sb_t;

    vec_t vecs[13];
    sb_t  sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   busy_cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter for measuring latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference: sign- or zero-extend to 48 bits, then multiply
    // modulo 2^48.
    function automatic logic [47:0] model(input logic [23:0] a, input logic [23:0] b, input bit sm);
        logic [47:0] ea, eb;
        ea = sm ? {{24{a[23]}}, a} : {24'b0, a};
        eb = sm ? {{24{b[23]}}, b} : {24'b0, b};
        return ea * eb;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge. Accepted at the next posedge if the unit is idle.
    task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b, input bit sm,
                                 input logic [47:0] exp);
        sb_t e;
        multiplicand = a;
        multiplier   = b;
        signed_mode  = sm;
        start        = 1'b1;
        e.expected     = exp;
        e.accept_cycle = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done. Returns at the negedge where done is high.
    task automatic finishOp(input string name);
        bit  ok;
        sb_t e;
        ok          = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: done not seen, expected within 40 cycles", name);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end else if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_scoreboard: done seen with no expected entry", name);
        end else begin
            e = sbq.pop_front();
            checkOutput({name, "_product"}, 64'(product), 64'(e.expected));
            checkOutput({name, "_latency"}, 64'(cyc - e.accept_cycle), 64'd25);
            checkOutput({name, "_busy_at_done"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        signed_mode  = 1'b0;

        vecs[0] = '{"u_max",      24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001};
        vecs[1] = '{"s_m1_m1",    24'hFFFFFF, 24'hFFFFFF, 1'b1, 48'h000000000001};
        vecs[2] = '{"s_min_3",    24'h800000, 24'h000003, 1'b1, 48'hFFFFFE800000};
        vecs[3] = '{"s_min_min",  24'h800000, 24'h800000, 1'b1, 48'h400000000000};
        vecs[4] = '{"u_min_min",  24'h800000, 24'h800000, 1'b0, 48'h400000000000};
        vecs[5] = '{"s_m1_1",     24'hFFFFFF, 24'h000001, 1'b1, 48'hFFFFFFFFFFFF};
        vecs[6] = '{"s_2_m2",     24'h000002, 24'hFFFFFE, 1'b1, 48'hFFFFFFFFFFFC};
        for (int i = 7; i < 13; i++) begin
            vecs[i].name     = $sformatf("rand%0d", i);
            vecs[i].a        = 24'($urandom);
            vecs[i].b        = 24'($urandom);
            vecs[i].sm       = 1'($urandom_range(0, 1));
            vecs[i].expected = model(vecs[i].a, vecs[i].b, vecs[i].sm);
        end

        #1;
        checkOutput("reset_product", 64'(product), 64'd0);
        checkOutput("reset_busy",    64'(busy),    64'd0);
        checkOutput("reset_done",    64'(done),    64'd0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].expected);
            finishOp(vecs[i].name);
            @(negedge clk);
        end

        // A zero operand still takes the full latency and pulses done once.
        applyStimulus(24'h000000, 24'h123456, 1'b0, 48'h0);
        finishOp("zero");
        checkOutput("zero_busy_cycles", 64'(busy_cycles), 64'd25);
        @(negedge clk);
        checkOutput("zero_done_single", 64'(done), 64'd0);

        // A start while busy is ignored. A start during done is accepted.
        applyStimulus(24'h000002, 24'h000003, 1'b0, 48'h6);
        repeat (8) @(negedge clk);
        multiplicand = 24'h000005;
        multiplier   = 24'h000005;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finishOp("hs_first");
        applyStimulus(24'h000005, 24'h000005, 1'b0, 48'h19);
        checkOutput("hs_product_held", 64'(product), 64'h6);
        finishOp("hs_second");
        @(negedge clk);

        // Abort at iteration 12. Start stays high through reset release.
        multiplicand = 24'h123456;
        multiplier   = 24'h654321;
        signed_mode  = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_busy",    64'(busy),    64'd0);
        checkOutput("abort_done",    64'(done),    64'd0);
        checkOutput("abort_product", 64'(product), 64'd0);
        multiplicand = 24'h000007;
        multiplier   = 24'h000009;
        start        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            sb_t e;
            e.expected     = 48'h3F;
            e.accept_cycle = cyc + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        finishOp("after_reset");
        @(negedge clk);

        checkOutput("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
